// File: rtl/mssb_scan_if.sv
// Stream bundle for mssb_scan: vector in, one set-bit index out per beat.
// Both handshakes are valid/ready; slave is the scanner side.
interface mssb_scan_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] i_in_vector;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [IDX_W-1:0] o_out_index;
  logic [CNT_W-1:0] o_out_seq;
  logic             o_out_last;
  logic             o_out_empty;

  modport slave (
    input  i_in_valid,
    output o_in_ready,
    input  i_in_vector,
    output o_out_valid,
    input  i_out_ready,
    output o_out_index,
    output o_out_seq,
    output o_out_last,
    output o_out_empty
  );

  modport master (
    output i_in_valid,
    input  o_in_ready,
    output i_in_vector,
    input  o_out_valid,
    output i_out_ready,
    input  o_out_index,
    input  o_out_seq,
    input  o_out_last,
    input  o_out_empty
  );
endinterface

// File: rtl/mssb_scan.sv
// Sequential set-bit scanner: streams the index of every set bit of an
// accepted vector, MSB-first or LSB-first, one beat per cycle.
module mssb_scan #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  mssb_scan_if.slave bus,
  output logic       o_busy
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] pick;
  logic [WIDTH-1:0] pick_mask;
  logic             one_left;
  logic             is_scan;
  logic             last;
  logic             out_hs;
  logic             accept;
  logic             in_ready;

  // Later loop iterations win, so the loop direction picks MSSB or LSSB.
  always_comb begin
    pick = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (rem_q[i]) pick = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rem_q[i]) pick = IDX_W'(i);
      end
    end
  end

  assign pick_mask = {{(WIDTH-1){1'b0}}, 1'b1} << pick;

  assign one_left = (rem_q != '0) &&
                    ((rem_q & (rem_q - 1'b1)) == '0);

  assign is_scan  = (state_q == SCAN);
  assign last     = is_scan && (empty_q || one_left);
  assign out_hs   = is_scan && bus.i_out_ready && !i_flush;
  assign in_ready = !i_flush &&
                    (!is_scan || (bus.i_out_ready && last));
  assign accept   = bus.i_in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
    empty_d = empty_q;
    unique case (1'b1)
      i_flush: begin
        state_d = IDLE;
        rem_d   = '0;
        seq_d   = '0;
        empty_d = 1'b0;
      end
      accept: begin
        state_d = SCAN;
        rem_d   = bus.i_in_vector;
        seq_d   = '0;
        empty_d = (bus.i_in_vector == '0);
      end
      (out_hs && !last): begin
        rem_d = rem_q & ~pick_mask;
        seq_d = seq_q + CNT_W'(1);
      end
      (out_hs && last && !bus.i_in_valid): begin
        // Clearing state on the way out keeps IDLE outputs at zero.
        state_d = IDLE;
        rem_d   = '0;
        seq_d   = '0;
        empty_d = 1'b0;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      empty_q <= empty_d;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_out_valid = is_scan;
  assign bus.o_out_index = pick;
  assign bus.o_out_seq   = seq_q;
  assign bus.o_out_last  = last;
  assign bus.o_out_empty = empty_q;
  assign o_busy          = is_scan;
endmodule

// File: tb/tb_mssb_scan.sv
// Bench for mssb_scan: three instances (16 MSB-first, 16 LSB-first,
// 9 MSB-first) checked against a beat-list model every cycle.
module tb_mssb_scan;
  typedef struct {
    int idx;
    int seq;
    bit last;
    bit empty;
  } beat_t;

  logic clk;
  logic rst_n;
  logic flush;

  logic        in_valid [3];
  logic [15:0] in_vec   [3];
  logic        out_ready[3];

  logic       o_valid[3];
  logic       o_rdy  [3];
  logic [7:0] o_idx  [3];
  logic [7:0] o_seq  [3];
  logic       o_last [3];
  logic       o_empty[3];
  logic       o_busy [3];

  beat_t exp_q[3][$];
  int    pops [3];
  int    checks;
  int    errors;

  mssb_scan_if #(.WIDTH(16)) if0 ();
  mssb_scan_if #(.WIDTH(16)) if1 ();
  mssb_scan_if #(.WIDTH(9))  if2 ();

  mssb_scan #(.WIDTH(16), .LSB_FIRST(1'b0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .bus(if0.slave), .o_busy(o_busy[0])
  );
  mssb_scan #(.WIDTH(16), .LSB_FIRST(1'b1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .bus(if1.slave), .o_busy(o_busy[1])
  );
  mssb_scan #(.WIDTH(9), .LSB_FIRST(1'b0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .bus(if2.slave), .o_busy(o_busy[2])
  );

  assign if0.i_in_valid  = in_valid[0];
  assign if0.i_in_vector = in_vec[0];
  assign if0.i_out_ready = out_ready[0];
  assign if1.i_in_valid  = in_valid[1];
  assign if1.i_in_vector = in_vec[1];
  assign if1.i_out_ready = out_ready[1];
  assign if2.i_in_valid  = in_valid[2];
  assign if2.i_in_vector = in_vec[2][8:0];
  assign if2.i_out_ready = out_ready[2];

  assign o_valid[0] = if0.o_out_valid;
  assign o_rdy[0]   = if0.o_in_ready;
  assign o_idx[0]   = 8'(if0.o_out_index);
  assign o_seq[0]   = 8'(if0.o_out_seq);
  assign o_last[0]  = if0.o_out_last;
  assign o_empty[0] = if0.o_out_empty;
  assign o_valid[1] = if1.o_out_valid;
  assign o_rdy[1]   = if1.o_in_ready;
  assign o_idx[1]   = 8'(if1.o_out_index);
  assign o_seq[1]   = 8'(if1.o_out_seq);
  assign o_last[1]  = if1.o_out_last;
  assign o_empty[1] = if1.o_out_empty;
  assign o_valid[2] = if2.o_out_valid;
  assign o_rdy[2]   = if2.o_in_ready;
  assign o_idx[2]   = 8'(if2.o_out_index);
  assign o_seq[2]   = 8'(if2.o_out_seq);
  assign o_last[2]  = if2.o_out_last;
  assign o_empty[2] = if2.o_out_empty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wd(int d);
    return (d == 2) ? 9 : 16;
  endfunction

  // Expected beats: set-bit indices in scan order, or one empty beat.
  task automatic push_beats(int d, logic [15:0] v);
    int    k;
    int    s;
    int    pos;
    beat_t b;
    k = 0;
    for (int i = 0; i < wd(d); i++) k += int'(v[i]);
    if (k == 0) begin
      b = '{idx: 0, seq: 0, last: 1'b1, empty: 1'b1};
      exp_q[d].push_back(b);
    end else begin
      s = 0;
      for (int n = 0; n < wd(d); n++) begin
        pos = (d == 1) ? n : wd(d) - 1 - n;
        if (v[pos]) begin
          b = '{idx: pos, seq: s, last: (s == k - 1), empty: 1'b0};
          exp_q[d].push_back(b);
          s++;
        end
      end
    end
  endtask

  always @(negedge rst_n) begin
    for (int d = 0; d < 3; d++) exp_q[d].delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        bit has;
        bit acc;
        has = exp_q[d].size() != 0;
        acc = in_valid[d] && !flush &&
              (!has || (out_ready[d] && exp_q[d][0].last));
        if (flush) begin
          exp_q[d].delete();
        end else begin
          if (has && out_ready[d]) begin
            void'(exp_q[d].pop_front());
            pops[d]++;
          end
          if (acc) push_beats(d, in_vec[d]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      bit has;
      bit er;
      has = exp_q[d].size() != 0;
      er  = !flush && (!has || (out_ready[d] && exp_q[d][0].last));
      chk($sformatf("valid%0d", d), int'(o_valid[d]), int'(has));
      chk($sformatf("busy%0d", d), int'(o_busy[d]), int'(has));
      chk($sformatf("in_ready%0d", d), int'(o_rdy[d]), int'(er));
      if (has && o_valid[d]) begin
        chk($sformatf("index%0d", d), int'(o_idx[d]), exp_q[d][0].idx);
        chk($sformatf("seq%0d", d), int'(o_seq[d]), exp_q[d][0].seq);
        chk($sformatf("last%0d", d), int'(o_last[d]),
            int'(exp_q[d][0].last));
        chk($sformatf("empty%0d", d), int'(o_empty[d]),
            int'(exp_q[d][0].empty));
      end
    end
  end

  task automatic send(int d, logic [15:0] v);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b1;
    in_vec[d]   = v;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (o_rdy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(int d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q[d].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  int lit_a[4] = '{15, 10, 5, 0};
  int lit_b[4] = '{0, 5, 10, 15};
  int p0;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_vec[d]    = '0;
      out_ready[d] = 1'b1;
      pops[d]      = 0;
    end

    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", int'(o_valid[d]), 0);
      chk("rst_busy", int'(o_busy[d]), 0);
      chk("rst_ready", int'(o_rdy[d]), 1);
      chk("rst_index", int'(o_idx[d]), 0);
      chk("rst_last", int'(o_last[d]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 0x8421 MSB-first, 0x0003 queued behind it with no bubble
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_vec[0]   = 16'h8421;
    @(posedge clk);
    #1;
    in_vec[0] = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_index", int'(o_idx[0]), lit_a[i]);
      chk("t1_seq", int'(o_seq[0]), i);
      chk("t1_last", int'(o_last[0]), int'(i == 3));
      if (i == 3) chk("t1_b2b_ready", int'(o_rdy[0]), 1);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_next_index", int'(o_idx[0]), 1);
    chk("t1_next_seq", int'(o_seq[0]), 0);
    drain(0);

    // 0x8421 LSB-first
    send(1, 16'h8421);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_index", int'(o_idx[1]), lit_b[i]);
      chk("t2_last", int'(o_last[1]), int'(i == 3));
    end
    drain(1);

    // zero vector
    send(0, 16'h0000);
    @(negedge clk);
    chk("t3_valid", int'(o_valid[0]), 1);
    chk("t3_index", int'(o_idx[0]), 0);
    chk("t3_seq", int'(o_seq[0]), 0);
    chk("t3_last", int'(o_last[0]), 1);
    chk("t3_empty", int'(o_empty[0]), 1);
    drain(0);
    chk("t3_busy", int'(o_busy[0]), 0);

    // WIDTH=9 all ones with ready toggling
    p0 = pops[2];
    send(2, 16'h01FF);
    for (int n = 0; n < 60; n++) begin
      if (exp_q[2].size() == 0) break;
      @(posedge clk);
      #1;
      out_ready[2] = ~out_ready[2];
    end
    out_ready[2] = 1'b1;
    drain(2);
    chk("t4_beats", pops[2] - p0, 9);

    // flush after first beat of 0x00F0
    send(0, 16'h00F0);
    @(negedge clk);
    chk("t5_first_index", int'(o_idx[0]), 7);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", int'(o_rdy[0]), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_valid", int'(o_valid[0]), 0);
    chk("t5_busy", int'(o_busy[0]), 0);
    send(0, 16'h0002);
    @(negedge clk);
    chk("t5_next_index", int'(o_idx[0]), 1);
    chk("t5_next_seq", int'(o_seq[0]), 0);
    chk("t5_next_last", int'(o_last[0]), 1);
    drain(0);

    // asynchronous reset mid-scan
    send(0, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(o_valid[0]), 0);
    chk("t6_async_busy", int'(o_busy[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 16'h0100);
    @(negedge clk);
    chk("t6_index", int'(o_idx[0]), 8);
    chk("t6_last", int'(o_last[0]), 1);
    drain(0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
